state_unpack_cit_unpack_polyvec_group: RTL and testbench
========================================================

// Module: state_unpack_cit_unpack_polyvec_group
// PURPOSE
//  Decompresses one 40-bit ciphertext group (5 bytes) into four 12-bit polynomial coefficients.
//  This is the receive-side inverse of the polyvec pack group. It is used by decryption to
//  rebuild u from c. Each 10-bit field t decodes as coeff = (t*KYBER_Q + 2^(d-1)) >> d, d = Comp_Bits.
//  One group is processed per enable. Decode is multi-cycle: one shared multiplier, one coefficient per cycle.
// PARAMETERS
//  KYBER_Q             3329  modulus used in decompression
//  Comp_Bits           10    compressed field width d
//  i_Ciphertext_Width  40    group width (4*Comp_Bits)
//  o_Coeffs_Width      12    output coefficient width
// PORTS
//  clk                 in   1   clock, rising edge
//  reset_n             in   1   asynchronous active-low reset
//  enable              in   1   start request, sampled only in IDLE
//  clear               in   1   synchronous abort; returns to IDLE; takes priority over enable
//  iCiphertext_Group   in   40  byte0 at [39:32] ... byte4 at [7:0]
//  oCoeffs             out  48  coeff0 at [47:36] ... coeff3 at [11:0]
//  Unpack_Group_done   out  1   one-cycle pulse; oCoeffs is valid from this cycle until the next done
// BEHAVIOUR
//  - Reset (async, reset_n=0): cstate=IDLE, oCoeffs=0, Unpack_Group_done=0, internal t/coeff regs=0.
//  - clear=1 at an edge has the same effect as reset, applied synchronously.
//  - FSM: IDLE -> LATCH -> DEC0 -> DEC1 -> DEC2 -> DEC3 -> DONE -> IDLE.
//    The only conditional transition is IDLE->LATCH, taken on enable=1. Undefined states go to IDLE.
//  - IDLE->LATCH: capture iCiphertext_Group. The input may change after this edge.
//  - LATCH->DEC0: split bytes b0..b4 into fields:
//    t0={b1[1:0],b0}, t1={b2[3:0],b1[7:2]}, t2={b3[5:0],b2[7:4]}, t3={b4,b3[7:6]}.
//  - DECi->next: coeff_i <= (t_i*KYBER_Q + 512) >> 10.
//    Product is 22 bits, unsigned, no truncation before the shift.
//    Result is always <= 3326 < Q, so no csubq is needed.
//  - DONE->IDLE: oCoeffs <= {coeff0,coeff1,coeff2,coeff3}; Unpack_Group_done <= 1.
//  - Any edge with cstate==IDLE drives Unpack_Group_done <= 0. oCoeffs holds its value.
//  - Latency: enable sampled at edge E; done=1 and new oCoeffs visible after edge E+6.
//  - Back-to-back: enable held high re-enters LATCH on the edge where done drops.
//    Throughput is one group per 7 cycles.
//  - enable while busy is ignored and not queued.
//  - clear or reset mid-decode: the partial result is discarded, done does not pulse,
//    and oCoeffs is forced to 0.
// CONFIGURATION
//  UNPACK_GROUP_BUSY_EN defined:
//   - adds output port Unpack_Group_busy (1 bit).
//   - Unpack_Group_busy = (cstate != IDLE), registered-state decode; 0 at reset and clear.
//  UNPACK_GROUP_BUSY_EN undefined:
//   - the port is absent; all other behaviour is identical.
// TESTING
//  1 zero: group 40'h0000000000 -> oCoeffs 48'h0, done pulses exactly one cycle, 6 edges after enable.
//  2 all-ones: group 40'hFFFFFFFFFF -> each coeff 3326, oCoeffs 48'hCFECFECFECFE.
//  3 single field: group 40'h0100000000 (t0=1) -> oCoeffs 48'h003000000000.
//  4 midpoint: group 40'h0002082080 (all t=512) -> oCoeffs 48'h681681681681 (1665 each).
//  5 back-to-back: enable held, groups from cases 2 then 4 -> done pulses 7 cycles apart,
//    with the correct oCoeffs each time.
//  6 abort: clear at DEC2, then reset_n low in a second run -> no done, oCoeffs=0, state IDLE;
//    a following enable decodes normally. Also run with UNPACK_GROUP_BUSY_EN defined and check
//    busy is high from edge E to edge E+6.

Source files
------------

// File: rtl/state_unpack_cit_unpack_polyvec_group.sv
`default_nettype none
// ============================================================================
// Module : state_unpack_cit_unpack_polyvec_group
// Brief  : Decompresses one 5-byte ciphertext group into four 12-bit Kyber
//          coefficients using one shared multiplier (one coefficient/cycle).
//          Optional busy output: define UNPACK_GROUP_BUSY_EN.
// Rev    : 1.0  initial release
// ============================================================================
module state_unpack_cit_unpack_polyvec_group #(
   parameter int KYBER_Q     = 3329,
   parameter int COMP_BITS   = 10,
   parameter int CT_WIDTH    = 4*COMP_BITS,
   parameter int COEFF_WIDTH = 12
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     enable,
   input  logic                     clear,
   input  logic [CT_WIDTH-1:0]      iCiphertext_Group,
   output logic [4*COEFF_WIDTH-1:0] oCoeffs,
`ifdef UNPACK_GROUP_BUSY_EN
   output logic                     Unpack_Group_busy,
`endif
   output logic                     Unpack_Group_done
);

   localparam int NCOEF  = 4;
   localparam int NBYTES = CT_WIDTH / 8;
   localparam int PROD_W = COMP_BITS + COEFF_WIDTH;
   localparam int ROUND  = 1 << (COMP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LATCH = 3'd1,
      S_DEC0  = 3'd2,
      S_DEC1  = 3'd3,
      S_DEC2  = 3'd4,
      S_DEC3  = 3'd5,
      S_DONE  = 3'd6
   } state_t;

   state_t                   state_q, state_d;
   logic [CT_WIDTH-1:0]      grp_q;
   logic [COMP_BITS-1:0]     t_q     [NCOEF];
   logic [COEFF_WIDTH-1:0]   coeff_q [NCOEF];
   logic [4*COEFF_WIDTH-1:0] coeffs_q;
   logic                     done_q;

   logic [CT_WIDTH-1:0]      grp_le;
   logic [1:0]               mul_idx;
   logic [COMP_BITS-1:0]     mul_op;
   logic [PROD_W-1:0]        prod;
   logic [COEFF_WIDTH-1:0]   coeff_new;

   // Byte 0 sits in the MSBs but fields are packed LSB-first, so byte-reverse
   // once and every field becomes a plain COMP_BITS-wide slice.
   for (genvar b = 0; b < NBYTES; b++) begin : g_byte_rev
      assign grp_le[b*8 +: 8] = grp_q[(NBYTES-1-b)*8 +: 8];
   end

   always_comb begin
      mul_idx = 2'd0;
      case (state_q)
         S_DEC1:  mul_idx = 2'd1;
         S_DEC2:  mul_idx = 2'd2;
         S_DEC3:  mul_idx = 2'd3;
         default: mul_idx = 2'd0;
      endcase
   end

   assign mul_op    = t_q[mul_idx];
   assign prod      = PROD_W'(mul_op) * PROD_W'(KYBER_Q) + PROD_W'(ROUND);
   assign coeff_new = prod[COMP_BITS +: COEFF_WIDTH];

   always_comb begin
      state_d = S_IDLE;
      case (state_q)
         S_IDLE:  state_d = enable ? S_LATCH : S_IDLE;
         S_LATCH: state_d = S_DEC0;
         S_DEC0:  state_d = S_DEC1;
         S_DEC1:  state_d = S_DEC2;
         S_DEC2:  state_d = S_DEC3;
         S_DEC3:  state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
      if (clear) state_d = S_IDLE;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= S_IDLE;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         grp_q    <= '0;
         coeffs_q <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < NCOEF; i++) begin
            t_q[i]     <= '0;
            coeff_q[i] <= '0;
         end
      end else if (clear) begin
         grp_q    <= '0;
         coeffs_q <= '0;
         done_q   <= 1'b0;
         for (int i = 0; i < NCOEF; i++) begin
            t_q[i]     <= '0;
            coeff_q[i] <= '0;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               done_q <= 1'b0;
               if (enable) grp_q <= iCiphertext_Group;
            end
            S_LATCH: begin
               for (int i = 0; i < NCOEF; i++)
                  t_q[i] <= grp_le[i*COMP_BITS +: COMP_BITS];
            end
            S_DEC0, S_DEC1, S_DEC2, S_DEC3: coeff_q[mul_idx] <= coeff_new;
            S_DONE: begin
               for (int i = 0; i < NCOEF; i++)
                  coeffs_q[(NCOEF-1-i)*COEFF_WIDTH +: COEFF_WIDTH] <= coeff_q[i];
               done_q <= 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign oCoeffs           = coeffs_q;
   assign Unpack_Group_done = done_q;
`ifdef UNPACK_GROUP_BUSY_EN
   assign Unpack_Group_busy = (state_q != S_IDLE);
`endif

endmodule
`default_nettype wire

// File: tb/tb_state_unpack_cit_unpack_polyvec_group.sv
`default_nettype none
// Scoreboard bench for the ciphertext group decompressor: the driver queues
// hand-computed coefficients with their expected arrival cycle, the monitor checks.
module tb_state_unpack_cit_unpack_polyvec_group;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        enable;
   logic        clear;
   logic [39:0] iCiphertext_Group;
   logic [47:0] oCoeffs;
   logic        Unpack_Group_done;
`ifdef UNPACK_GROUP_BUSY_EN
   logic        Unpack_Group_busy;
`endif

   state_unpack_cit_unpack_polyvec_group dut (
      .clk               (clk),
      .reset_n           (reset_n),
      .enable            (enable),
      .clear             (clear),
      .iCiphertext_Group (iCiphertext_Group),
      .oCoeffs           (oCoeffs),
`ifdef UNPACK_GROUP_BUSY_EN
      .Unpack_Group_busy (Unpack_Group_busy),
`endif
      .Unpack_Group_done (Unpack_Group_done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [47:0] coeffs;
      int unsigned cy;
   } exp_t;

   exp_t        sb[$];
   int unsigned cyc = 0;
   int          total = 0;
   int          bad = 0;
   logic        chk_width = 1'b0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [47:0] act, input logic [47:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse must match the head of the scoreboard.
   always @(negedge clk) begin
      exp_t e;
      if (chk_width) begin
         total++;
         if (Unpack_Group_done !== 1'b0) begin
            bad++;
            $display("FAIL done_width: done still %b one cycle later, required 0", Unpack_Group_done);
         end
      end
      chk_width = 1'b0;
      if (Unpack_Group_done === 1'b1) begin
         chk_width = 1'b1;
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_done: done pulsed at cycle %0d with nothing expected", cyc);
         end else begin
            e = sb.pop_front();
            total++;
            if (oCoeffs !== e.coeffs) begin
               bad++;
               $display("FAIL coeffs: got %h expected %h", oCoeffs, e.coeffs);
            end
            total++;
            if (cyc != e.cy) begin
               bad++;
               $display("FAIL latency: done at cycle %0d expected cycle %0d", cyc, e.cy);
            end
         end
      end
   end

   task automatic busy_check(input logic exp);
`ifdef UNPACK_GROUP_BUSY_EN
      check("busy", {47'd0, Unpack_Group_busy}, {47'd0, exp});
`else
      if (exp === 1'bx) $display("busy x");
`endif
   endtask

   // Issue one group and wait until its done cycle has passed.
   task automatic run_group(input logic [39:0] g, input logic [47:0] e);
      @(negedge clk);
      iCiphertext_Group = g;
      enable            = 1'b1;
      sb.push_back('{e, cyc + 7});
      @(negedge clk);
      enable            = 1'b0;
      iCiphertext_Group = ~g;
      busy_check(1'b1);
      for (int k = 1; k < 8; k++) begin
         @(negedge clk);
         if (k <= 6) busy_check(k < 6);
      end
   endtask

   // Start a decode and abort it while in DEC2, by clear or by reset.
   task automatic abort_run(input logic use_reset);
      @(negedge clk);
      iCiphertext_Group = 40'hFFFFFFFFFF;
      enable            = 1'b1;
      @(negedge clk);
      enable = 1'b0;
      repeat (3) @(negedge clk);
      if (use_reset) begin
         reset_n = 1'b0;
         #1;
         check("rst_abort_coeffs", oCoeffs, 48'h0);
         check("rst_abort_done", {47'd0, Unpack_Group_done}, 48'h0);
         busy_check(1'b0);
         @(negedge clk);
         reset_n = 1'b1;
      end else begin
         clear = 1'b1;
         @(negedge clk);
         clear = 1'b0;
         check("clr_abort_coeffs", oCoeffs, 48'h0);
         check("clr_abort_done", {47'd0, Unpack_Group_done}, 48'h0);
         busy_check(1'b0);
      end
      repeat (9) @(negedge clk);
      check("abort_no_done", {47'd0, Unpack_Group_done}, 48'h0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      reset_n           = 1'b0;
      enable            = 1'b0;
      clear             = 1'b0;
      iCiphertext_Group = 40'h0;
      repeat (3) @(negedge clk);
      check("reset_coeffs", oCoeffs, 48'h0);
      check("reset_done", {47'd0, Unpack_Group_done}, 48'h0);
      busy_check(1'b0);
      reset_n = 1'b1;
      @(negedge clk);

      run_group(40'h0000000000, 48'h000000000000);
      run_group(40'hFFFFFFFFFF, 48'hCFECFECFECFE);
      run_group(40'h0100000000, 48'h003000000000);
      run_group(40'h0002082080, 48'h681681681681);

      // Back-to-back with enable held: second group captured 7 edges later.
      @(negedge clk);
      iCiphertext_Group = 40'hFFFFFFFFFF;
      enable            = 1'b1;
      sb.push_back('{48'hCFECFECFECFE, cyc + 7});
      @(negedge clk);
      iCiphertext_Group = 40'h0002082080;
      sb.push_back('{48'h681681681681, cyc + 13});
      repeat (7) @(negedge clk);
      enable            = 1'b0;
      iCiphertext_Group = 40'h0;
      repeat (8) @(negedge clk);

      abort_run(1'b0);
      run_group(40'hFFFFFFFFFF, 48'hCFECFECFECFE);
      abort_run(1'b1);
      run_group(40'h0100000000, 48'h003000000000);

      repeat (4) @(negedge clk);
      check("scoreboard_empty", 48'(sb.size()), 48'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
